pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Registered program-counter sequencer for the Harvard MIPS core. Holds the fetch PC,
//  resolves branches/jumps with optional MIPS delay-slot semantics, emits link writes,
//  and detects the halt address. Sits between instruction memory and the register file.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  PC value loaded on reset
//  HALT_ADDR     32'h00000000  redirect target that halts the core
//  DELAY_SLOTS   1             1: one architectural delay slot; 0: immediate redirect
//  EXC_VECTOR    32'hBFC00180  PC loaded on address error (PC_ADDR_ERR_EN only)
// PORTS
//  clk        in   1   core clock, all state on rising edge
//  reset      in   1   synchronous, active-high
//  stall      in   1   1: hold all state; no decision is taken this edge
//  branch     in   1   current instruction is a conditional branch
//  jump       in   1   current instruction is J/JAL/JR/JALR
//  instr      in   32  instruction at pc (opcode, rt, rd, imm16, index26, bit0)
//  eq         in   1   rs==rt (BEQ/BNE) or rs==0 (REGIMM/BGTZ/BLEZ)
//  lt         in   1   rs<0 signed
//  reg_read   in   32  rs value for JR/JALR
//  pc         out  32  fetch address
//  delay_slot out  1   1: instruction at pc is a delay slot
//  link_we    out  1   one-cycle link-write strobe
//  link_dst   out  5   31 for JAL/BGEZAL/BLTZAL, instr[15:11] for JALR
//  link_addr  out  32  return address
//  active     out  1   0 once halted
//  addr_err   out  1   misaligned register jump (tied 0 without PC_ADDR_ERR_EN)
// BEHAVIOUR
//  Reset: pc=RESET_VECTOR, state RUN, delay_slot=0, link_we=0, link_dst=0, link_addr=0,
//   active=1, addr_err=0. Reset in any state (incl. DELAY, HALT) discards pending target.
//  Decision edge = rising edge with reset=0, stall=0, state RUN. P = pc at that edge.
//  Taken: opcode 000100 eq; 000101 !eq; 000111 !eq&&!lt; 000110 eq||lt; 000001 with
//   rt 00001/10001 !lt, rt 00000/10000 lt. Unknown opcode -> not taken. branch beats jump.
//  Targets: branch P+4+(sext(imm16)<<2), mod 2^32; J/JAL {(P+4)[31:28],index26,2'b00};
//   JR/JALR (opcode 000000, instr[0]=0/1) reg_read.
//  Link: JAL, JALR, BGEZAL, BLTZAL write link whether or not taken; link_addr=P+8
//   (DELAY_SLOTS=1) or P+4 (DELAY_SLOTS=0). link_we high exactly one cycle after the
//   decision edge, independent of stall.
//  FSM RUN/DELAY/HALT:
//   RUN, not taken: pc<=P+4.
//   RUN, taken, DELAY_SLOTS=1: pc<=P+4, pending<=target, delay_slot<=1, ->DELAY.
//   RUN, taken, DELAY_SLOTS=0: pc<=target (or HALT rule), stay RUN.
//   DELAY, unstalled edge: pc<=pending, delay_slot<=0, ->RUN; branch/jump in slot ignored.
//   Redirect to HALT_ADDR: pc<=HALT_ADDR, ->HALT, active<=0.
//   HALT: all inputs ignored until reset; pc holds HALT_ADDR.
//  stall=1: pc, state, pending, delay_slot hold; link_we still self-clears.
// CONFIGURATION
//  PC_ADDR_ERR_EN defined: JR/JALR with reg_read[1:0]!=0 -> no redirect, no link write;
//   pc<=EXC_VECTOR on decision edge (delay slot skipped), ->RUN, addr_err high 1 cycle.
//  Undefined: reg_read[1:0] forced to 00, addr_err tied 0.
// TESTING
//  reset, no branches, 3 edges -> pc BFC00000,BFC00004,BFC00008,BFC0000C; active=1
//  BEQ eq=1 imm=0x0004 at P=BFC00010, DELAY_SLOTS=1 -> pc BFC00014 (delay_slot=1) then BFC00024
//  BLTZAL lt=0 at P=BFC00020 -> not taken, pc BFC00024; link_we=1, link_dst=31, link_addr=BFC00028
//  JR reg_read=0 with stall=1 on the slot edge -> pc holds BFC0xxxx+4, then 0; active=0, held until reset
//  taken BNE then reset during DELAY -> pc=BFC00000, delay_slot=0, pending target never loaded
//  PC_ADDR_ERR_EN, JALR reg_read=0x00400002 -> pc=BFC00180, addr_err pulse, link_we=0

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: branch/jump resolution with optional delay slot, link writes, halt detection.
// Optional feature macro: PC_ADDR_ERR_EN enables the misaligned register-jump exception path.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000,
    parameter int          DELAY_SLOTS  = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic [31:0] instr,
    input  logic        eq,
    input  logic        lt,
    input  logic [31:0] reg_read,
    output logic [31:0] pc,
    output logic        delay_slot,
    output logic        link_we,
    output logic [4:0]  link_dst,
    output logic [31:0] link_addr,
    output logic        active,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DELAY = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pending_r;

    logic [5:0]  opcode_s;
    logic [4:0]  rt_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] link_ret_s;
    logic [31:0] br_target_s;
    logic [31:0] j_target_s;
    logic [31:0] reg_target_s;
    logic        reg_misaligned_s;
    logic        taken_s;
    logic        is_link_s;
    logic [4:0]  link_sel_s;
    logic [31:0] target_s;
    logic        misalign_s;

    assign opcode_s         = instr[31:26];
    assign rt_s             = instr[20:16];
    assign pc_plus4_s       = pc + 32'd4;
    assign link_ret_s       = (DELAY_SLOTS != 0) ? (pc + 32'd8) : pc_plus4_s;
    assign br_target_s      = pc_plus4_s + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign j_target_s       = {pc_plus4_s[31:28], instr[25:0], 2'b00};
    assign reg_misaligned_s = (reg_read[1:0] != 2'b00);

    // Register-jump target: without the exception path the low bits are simply dropped
`ifdef PC_ADDR_ERR_EN
    assign reg_target_s = reg_read;
`else
    assign reg_target_s = reg_misaligned_s ? {reg_read[31:2], 2'b00} : reg_read;
`endif

    // Decode the instruction at pc into taken/target/link decisions; branch wins over jump
    always_comb begin
        taken_s    = 1'b0;
        is_link_s  = 1'b0;
        link_sel_s = 5'd31;
        target_s   = pc_plus4_s;
        misalign_s = 1'b0;
        if (branch) begin
            target_s = br_target_s;
            case (opcode_s)
                6'b000100: taken_s = eq;
                6'b000101: taken_s = !eq;
                6'b000111: taken_s = !eq && !lt;
                6'b000110: taken_s = eq || lt;
                6'b000001: begin
                    case (rt_s)
                        5'b00001: taken_s = !lt;
                        5'b10001: begin
                            taken_s   = !lt;
                            is_link_s = 1'b1;
                        end
                        5'b00000: taken_s = lt;
                        5'b10000: begin
                            taken_s   = lt;
                            is_link_s = 1'b1;
                        end
                        default: taken_s = 1'b0;
                    endcase
                end
                default: taken_s = 1'b0;
            endcase
        end else if (jump) begin
            case (opcode_s)
                6'b000010: begin
                    taken_s  = 1'b1;
                    target_s = j_target_s;
                end
                6'b000011: begin
                    taken_s   = 1'b1;
                    target_s  = j_target_s;
                    is_link_s = 1'b1;
                end
                6'b000000: begin
                    taken_s    = 1'b1;
                    target_s   = reg_target_s;
                    is_link_s  = instr[0];
                    link_sel_s = instr[15:11];
`ifdef PC_ADDR_ERR_EN
                    misalign_s = reg_misaligned_s;
`else
                    misalign_s = 1'b0;
`endif
                end
                default: taken_s = 1'b0;
            endcase
        end else begin
            taken_s = 1'b0;
        end
    end

    // Sequencer FSM with all outputs registered; link_we and addr_err self-clear every edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_RUN;
            pc         <= RESET_VECTOR;
            pending_r  <= 32'h00000000;
            delay_slot <= 1'b0;
            link_we    <= 1'b0;
            link_dst   <= 5'd0;
            link_addr  <= 32'h00000000;
            active     <= 1'b1;
            addr_err   <= 1'b0;
        end else begin
            link_we  <= 1'b0;
            addr_err <= 1'b0;
            if (!stall) begin
                case (state_r)
                    ST_RUN: begin
                        if (misalign_s) begin
                            pc         <= EXC_VECTOR;
                            delay_slot <= 1'b0;
                            addr_err   <= 1'b1;
                        end else begin
                            if (is_link_s) begin
                                link_we   <= 1'b1;
                                link_dst  <= link_sel_s;
                                link_addr <= link_ret_s;
                            end else begin
                                link_we <= 1'b0;
                            end
                            if (taken_s && (DELAY_SLOTS != 0)) begin
                                pc         <= pc_plus4_s;
                                pending_r  <= target_s;
                                delay_slot <= 1'b1;
                                state_r    <= ST_DELAY;
                            end else if (taken_s) begin
                                pc <= target_s;
                                if (target_s == HALT_ADDR) begin
                                    state_r <= ST_HALT;
                                    active  <= 1'b0;
                                end else begin
                                    state_r <= ST_RUN;
                                end
                            end else begin
                                pc <= pc_plus4_s;
                            end
                        end
                    end
                    ST_DELAY: begin
                        pc         <= pending_r;
                        delay_slot <= 1'b0;
                        if (pending_r == HALT_ADDR) begin
                            state_r <= ST_HALT;
                            active  <= 1'b0;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_HALT: begin
                        pc     <= HALT_ADDR;
                        active <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_HALT;
                        pc      <= HALT_ADDR;
                        active  <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: expected outputs queued with each stimulus, checked after the edge.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        jump;
    logic [31:0] instr;
    logic        eq;
    logic        lt;
    logic [31:0] reg_read;
    logic [31:0] pc;
    logic        delay_slot;
    logic        link_we;
    logic [4:0]  link_dst;
    logic [31:0] link_addr;
    logic        active;
    logic        addr_err;

    typedef struct packed {
        logic [31:0] pc;
        logic        ds;
        logic        lwe;
        logic [4:0]  ldst;
        logic [31:0] laddr;
        logic        act;
        logic        aerr;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    logic [4:0]  exp_ldst;
    logic [31:0] exp_laddr;
    logic [31:0] p;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .jump(jump),
        .instr(instr), .eq(eq), .lt(lt), .reg_read(reg_read),
        .pc(pc), .delay_slot(delay_slot), .link_we(link_we), .link_dst(link_dst),
        .link_addr(link_addr), .active(active), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic st, input logic br, input logic jp,
                         input logic [31:0] ins, input logic e, input logic l, input logic [31:0] rr);
        reset = rs; stall = st; branch = br; jump = jp;
        instr = ins; eq = e; lt = l; reg_read = rr;
    endtask

    // Queue the expectation for the coming edge, let it happen, then pop and compare.
    task automatic tick(input logic [31:0] e_pc, input logic e_ds, input logic e_lwe,
                        input logic e_act, input logic e_aerr);
        exp_t e;
        exp_t got;
        e = '{pc: e_pc, ds: e_ds, lwe: e_lwe, ldst: exp_ldst, laddr: exp_laddr,
              act: e_act, aerr: e_aerr};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("pc", pc, got.pc);
        chk("delay_slot", {31'd0, delay_slot}, {31'd0, got.ds});
        chk("link_we", {31'd0, link_we}, {31'd0, got.lwe});
        chk("link_dst", {27'd0, link_dst}, {27'd0, got.ldst});
        chk("link_addr", link_addr, got.laddr);
        chk("active", {31'd0, active}, {31'd0, got.act});
        chk("addr_err", {31'd0, addr_err}, {31'd0, got.aerr});
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000);
    endtask

    localparam logic [31:0] BEQ4     = {6'b000100, 5'd0, 5'd0, 16'h0004};
    localparam logic [31:0] BNE_I    = {6'b000101, 5'd0, 5'd0, 16'h0010};
    localparam logic [31:0] BLTZAL   = {6'b000001, 5'd0, 5'b10000, 16'h0008};
    localparam logic [31:0] BGTZ_M1  = {6'b000111, 5'd0, 5'd0, 16'hFFFF};
    localparam logic [31:0] UNK      = {6'b001000, 5'd0, 5'd0, 16'h0004};
    localparam logic [31:0] JAL_I    = {6'b000011, 26'h0000100};
    localparam logic [31:0] JALR7    = {6'b000000, 5'd0, 5'd0, 5'd7, 10'd0, 1'b1};
    localparam logic [31:0] JALR9    = {6'b000000, 5'd0, 5'd0, 5'd9, 10'd0, 1'b1};
    localparam logic [31:0] JR_I     = {6'b000000, 5'd0, 5'd0, 5'd0, 10'd0, 1'b0};

    initial begin
        checks = 0; errors = 0;
        exp_ldst = 5'd0; exp_laddr = 32'h00000000;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000);
        tick(32'hBFC00000, 1'b0, 1'b0, 1'b1, 1'b0);

        // straight-line fetch
        tick(32'hBFC00004, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(32'hBFC00008, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(32'hBFC0000C, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(32'hBFC00010, 1'b0, 1'b0, 1'b1, 1'b0);

        // taken BEQ with delay slot
        drive(1'b0, 1'b0, 1'b1, 1'b0, BEQ4, 1'b1, 1'b0, 32'h00000000);
        tick(32'hBFC00014, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(32'hBFC00024, 1'b0, 1'b0, 1'b1, 1'b0);

        // BLTZAL not taken still links
        drive(1'b0, 1'b0, 1'b1, 1'b0, BLTZAL, 1'b0, 1'b0, 32'h00000000);
        exp_ldst = 5'd31; exp_laddr = 32'hBFC0002C;
        tick(32'hBFC00028, 1'b0, 1'b1, 1'b1, 1'b0);

        // stall holds pc, ignores the branch, link_we self-clears
        drive(1'b0, 1'b1, 1'b1, 1'b0, BEQ4, 1'b1, 1'b0, 32'h00000000);
        tick(32'hBFC00028, 1'b0, 1'b0, 1'b1, 1'b0);

        // JAL, with a taken-looking branch in its slot that must be ignored
        drive(1'b0, 1'b0, 1'b0, 1'b1, JAL_I, 1'b0, 1'b0, 32'h00000000);
        exp_laddr = 32'hBFC00030;
        tick(32'hBFC0002C, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, BEQ4, 1'b1, 1'b0, 32'h00000000);
        tick(32'hB0000400, 1'b0, 1'b0, 1'b1, 1'b0);

        // JALR to rd=7 with a stalled slot edge
        drive(1'b0, 1'b0, 1'b0, 1'b1, JALR7, 1'b0, 1'b0, 32'h00400000);
        exp_ldst = 5'd7; exp_laddr = 32'hB0000408;
        tick(32'hB0000404, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000);
        tick(32'hB0000404, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(32'h00400000, 1'b0, 1'b0, 1'b1, 1'b0);

        // branch beats jump: BNE with eq=1 is not taken, the jump is ignored
        drive(1'b0, 1'b0, 1'b1, 1'b1, BNE_I, 1'b1, 1'b0, 32'h00000000);
        tick(32'h00400004, 1'b0, 1'b0, 1'b1, 1'b0);

        // BGTZ with negative offset lands back on itself
        drive(1'b0, 1'b0, 1'b1, 1'b0, BGTZ_M1, 1'b0, 1'b0, 32'h00000000);
        tick(32'h00400008, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(32'h00400004, 1'b0, 1'b0, 1'b1, 1'b0);

        // unknown branch opcode is not taken
        drive(1'b0, 1'b0, 1'b1, 1'b0, UNK, 1'b1, 1'b1, 32'h00000000);
        tick(32'h00400008, 1'b0, 1'b0, 1'b1, 1'b0);

        // misaligned JALR
        drive(1'b0, 1'b0, 1'b0, 1'b1, JALR9, 1'b0, 1'b0, 32'h00400012);
`ifdef PC_ADDR_ERR_EN
        tick(32'hBFC00180, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(32'hBFC00184, 1'b0, 1'b0, 1'b1, 1'b0);
        p = 32'hBFC00184;
`else
        exp_ldst = 5'd9; exp_laddr = 32'h00400010;
        tick(32'h0040000C, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(32'h00400010, 1'b0, 1'b0, 1'b1, 1'b0);
        p = 32'h00400010;
`endif

        // taken BNE, then reset in the delay slot discards the target
        drive(1'b0, 1'b0, 1'b1, 1'b0, BNE_I, 1'b0, 1'b0, 32'h00000000);
        tick(p + 32'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000);
        exp_ldst = 5'd0; exp_laddr = 32'h00000000;
        tick(32'hBFC00000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(32'hBFC00004, 1'b0, 1'b0, 1'b1, 1'b0);

        // JR to the halt address with a stalled slot
        drive(1'b0, 1'b0, 1'b0, 1'b1, JR_I, 1'b0, 1'b0, 32'h00000000);
        tick(32'hBFC00008, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000);
        tick(32'hBFC00008, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);

        // halted: inputs ignored
        drive(1'b0, 1'b0, 1'b0, 1'b1, JAL_I, 1'b0, 1'b0, 32'h00000000);
        tick(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, BLTZAL, 1'b0, 1'b1, 32'h00000000);
        tick(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset leaves halt
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000);
        tick(32'hBFC00000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(32'hBFC00004, 1'b0, 1'b0, 1'b1, 1'b0);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
